sprite_renderer: RTL and testbench

//  Consumer side of the object-control move/position interface. Turns move pulses and

---
 rtl/sprite_renderer_if.sv | 34 +++
 rtl/sprite_renderer.sv | 222 ++++++++++++++++++++++
 tb/tb_sprite_renderer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_renderer_if.sv
// Object-controller to renderer bus: move pulses and positions in,
// VGA adapter pixel writes and busy status out.
interface sprite_renderer_if;
  logic       clear;
  logic       player_move;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic       bullet_move;
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic       enemy_move;
  logic [7:0] enemy_x;
  logic [6:0] enemy_y;
  logic [2:0] enemy_width;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  modport master (
    output clear, player_move, player_x, player_y,
    output bullet_move, bullet_x, bullet_y,
    output enemy_move, enemy_x, enemy_y, enemy_width,
    input  vga_x, vga_y, colour, plot, busy
  );

  modport slave (
    input  clear, player_move, player_x, player_y,
    input  bullet_move, bullet_x, bullet_y,
    input  enemy_move, enemy_x, enemy_y, enemy_width,
    output vga_x, vga_y, colour, plot, busy
  );
endinterface

// File: rtl/sprite_renderer.sv
// Sprite renderer: erases each object's previous box and draws the new one,
// one pixel per clock, and performs full-screen clears followed by a redraw.
module sprite_renderer #(
  parameter int unsigned PLAYER_W      = 3,
  parameter int unsigned BULLET_W      = 1,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [2:0]  PLAYER_COLOUR = 3'b010,
  parameter logic [2:0]  BULLET_COLOUR = 3'b111,
  parameter logic [2:0]  ENEMY_COLOUR  = 3'b100
) (
  input logic              clk,
  input logic              reset,
  sprite_renderer_if.slave bus
);
  localparam logic [7:0] SCR_W_M1   = 8'd159;
  localparam logic [6:0] SCR_H_M1   = 7'd119;
  localparam logic [1:0] OBJ_PLAYER = 2'd0;
  localparam logic [1:0] OBJ_BULLET = 2'd1;
  localparam logic [1:0] OBJ_ENEMY  = 2'd2;
  localparam logic [2:0] PLAYER_W3  = 3'(PLAYER_W);
  localparam logic [2:0] BULLET_W3  = 3'(BULLET_W);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_ERASE = 2'd2, S_DRAW = 2'd3} state_e;

  function automatic logic [2:0] obj_colour(input logic [1:0] obj);
    case (obj)
      OBJ_PLAYER: return PLAYER_COLOUR;
      OBJ_BULLET: return BULLET_COLOUR;
      default:    return ENEMY_COLOUR;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic       clr_p_q, clr_p_d, ply_p_q, ply_p_d, bul_p_q, bul_p_d, eny_p_q, eny_p_d;
  logic [1:0] obj_q, obj_d;
  logic [7:0] new_x_q, new_x_d;
  logic [6:0] new_y_q, new_y_d;
  logic [2:0] new_w_q, new_w_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [7:0] old_x_q [3];
  logic [6:0] old_y_q [3];
  logic [2:0] old_w_q [3];
  logic       upd_old_s, wipe_old_s;
  logic [1:0] sel_s;
  logic [7:0] sel_x_s;
  logic [6:0] sel_y_s;
  logic [2:0] sel_w_s;
  logic       any_obj_s;
  logic [7:0] box_x_s;
  logic [6:0] box_y_s;
  logic [2:0] box_w_s;
  logic [8:0] pix_x_s;
  logic [7:0] pix_y_s;
  logic       box_last_x_s, box_last_y_s, on_screen_s;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d;

  // Fixed-priority pick among pending objects (player > bullet > enemy) and its inputs.
  always_comb begin
    any_obj_s = ply_p_q | bul_p_q | eny_p_q;
    if (ply_p_q) begin
      sel_s = OBJ_PLAYER; sel_x_s = bus.player_x; sel_y_s = bus.player_y; sel_w_s = PLAYER_W3;
    end else if (bul_p_q) begin
      sel_s = OBJ_BULLET; sel_x_s = bus.bullet_x; sel_y_s = bus.bullet_y; sel_w_s = BULLET_W3;
    end else begin
      sel_s = OBJ_ENEMY;  sel_x_s = bus.enemy_x;  sel_y_s = bus.enemy_y;  sel_w_s = bus.enemy_width;
    end
  end

  // Current box geometry; pixel sums are widened so off-screen pixels never wrap.
  always_comb begin
    if (state_q == S_ERASE) begin
      box_x_s = old_x_q[obj_q]; box_y_s = old_y_q[obj_q]; box_w_s = old_w_q[obj_q];
    end else begin
      box_x_s = new_x_q; box_y_s = new_y_q; box_w_s = new_w_q;
    end
    pix_x_s      = {1'b0, box_x_s} + {1'b0, cx_q};
    pix_y_s      = {1'b0, box_y_s} + {1'b0, cy_q};
    box_last_x_s = (cx_q == ({5'd0, box_w_s} - 8'd1));
    box_last_y_s = (cy_q == ({4'd0, box_w_s} - 7'd1));
    on_screen_s  = (pix_x_s < 9'd160) && (pix_y_s < 8'd120);
  end

  // Next-state logic: arbitration, box/screen scan counters and pending-flag bookkeeping.
  always_comb begin
    state_d = state_q;
    clr_p_d = clr_p_q; ply_p_d = ply_p_q; bul_p_d = bul_p_q; eny_p_d = eny_p_q;
    obj_d = obj_q; new_x_d = new_x_q; new_y_d = new_y_q; new_w_d = new_w_q;
    cx_d = cx_q; cy_d = cy_q;
    upd_old_s = 1'b0; wipe_old_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_p_q) begin
          clr_p_d = 1'b0; cx_d = 8'd0; cy_d = 7'd0; state_d = S_CLEAR;
        end else if (any_obj_s) begin
          if (sel_s == OBJ_PLAYER) begin
            ply_p_d = 1'b0;
          end else if (sel_s == OBJ_BULLET) begin
            bul_p_d = 1'b0;
          end else begin
            eny_p_d = 1'b0;
          end
          obj_d = sel_s; new_x_d = sel_x_s; new_y_d = sel_y_s; new_w_d = sel_w_s;
          cx_d = 8'd0; cy_d = 7'd0;
          if (old_w_q[sel_s] != 3'd0) begin
            state_d = S_ERASE;
          end else if (sel_w_s != 3'd0) begin
            state_d = S_DRAW;
          end else begin
            upd_old_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (cx_q == SCR_W_M1) begin
          cx_d = 8'd0;
          if (cy_q == SCR_H_M1) begin
            cy_d = 7'd0; wipe_old_s = 1'b1;
            ply_p_d = 1'b1; bul_p_d = 1'b1; eny_p_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_ERASE, S_DRAW: begin
        if (box_last_x_s) begin
          cx_d = 8'd0;
          if (box_last_y_s) begin
            cy_d = 7'd0;
            if (state_q == S_ERASE && new_w_q != 3'd0) begin
              state_d = S_DRAW;
            end else begin
              upd_old_s = 1'b1; state_d = S_IDLE;
            end
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new pulse always wins over a same-cycle service clear.
    clr_p_d = clr_p_d | bus.clear;
    ply_p_d = ply_p_d | bus.player_move;
    bul_p_d = bul_p_d | bus.bullet_move;
    eny_p_d = eny_p_d | bus.enemy_move;
  end

  // Pixel write for the pixel currently addressed; coordinates/colour hold while idle.
  always_comb begin
    vga_x_d = vga_x_q; vga_y_d = vga_y_q; colour_d = colour_q; plot_d = 1'b0;
    case (state_q)
      S_CLEAR: begin
        vga_x_d = cx_q; vga_y_d = cy_q; colour_d = BG_COLOUR; plot_d = 1'b1;
      end
      S_ERASE: begin
        vga_x_d = pix_x_s[7:0]; vga_y_d = pix_y_s[6:0]; colour_d = BG_COLOUR; plot_d = on_screen_s;
      end
      S_DRAW: begin
        vga_x_d = pix_x_s[7:0]; vga_y_d = pix_y_s[6:0]; colour_d = obj_colour(obj_q); plot_d = on_screen_s;
      end
      default: plot_d = 1'b0;
    endcase
    // Busy also covers accepted-but-unserved work so it does not dip between queued objects.
    busy_d = (state_d != S_IDLE) | clr_p_d | ply_p_d | bul_p_d | eny_p_d;
  end

  // State, flags, latched object and scan counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      clr_p_q <= 1'b0; ply_p_q <= 1'b0; bul_p_q <= 1'b0; eny_p_q <= 1'b0;
      obj_q <= 2'd0; new_x_q <= 8'd0; new_y_q <= 7'd0; new_w_q <= 3'd0;
      cx_q <= 8'd0; cy_q <= 7'd0;
    end else begin
      state_q <= state_d;
      clr_p_q <= clr_p_d; ply_p_q <= ply_p_d; bul_p_q <= bul_p_d; eny_p_q <= eny_p_d;
      obj_q <= obj_d; new_x_q <= new_x_d; new_y_q <= new_y_d; new_w_q <= new_w_d;
      cx_q <= cx_d; cy_q <= cy_d;
    end
  end

  // Remembered on-screen box per object, used by the next erase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        old_x_q[i] <= 8'd0; old_y_q[i] <= 7'd0; old_w_q[i] <= 3'd0;
      end
    end else if (wipe_old_s) begin
      for (int i = 0; i < 3; i++) begin
        old_w_q[i] <= 3'd0;
      end
    end else if (upd_old_s) begin
      old_x_q[obj_d] <= new_x_d; old_y_q[obj_d] <= new_y_d; old_w_q[obj_d] <= new_w_d;
    end
  end

  // Registered outputs to the VGA adapter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_x_q <= 8'd0; vga_y_q <= 7'd0; colour_q <= 3'd0; plot_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      vga_x_q <= vga_x_d; vga_y_q <= vga_y_d; colour_q <= colour_d; plot_q <= plot_d; busy_q <= busy_d;
    end
  end

  assign bus.vga_x  = vga_x_q;
  assign bus.vga_y  = vga_y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer: every plotted pixel is captured and
// compared against a pixel list built from box/erase/clear rules.
module tb_sprite_renderer;
  localparam logic [2:0] BG = 3'b000;
  localparam logic [2:0] OBJ_COL [3] = '{3'b010, 3'b111, 3'b100};

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   t_pulse;

  sprite_renderer_if bus();
  sprite_renderer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  int          got_c[$];

  always @(negedge clk) begin
    if (bus.plot === 1'b1) begin
      got_q.push_back({bus.vga_x, bus.vga_y, bus.colour});
      got_c.push_back(cyc);
    end
  end

  // Reference state: what each object currently has on screen, and what the bench drives.
  int mx[3], my[3], mw[3];
  int in_x[3], in_y[3], in_w[3];

  task automatic m_box(input int x, input int y, input int w, input logic [2:0] c);
    for (int j = 0; j < w; j++)
      for (int i = 0; i < w; i++)
        if (x + i < 160 && y + j < 120) exp_q.push_back({8'(x + i), 7'(y + j), c});
  endtask

  task automatic m_obj(input int o);
    m_box(mx[o], my[o], mw[o], BG);
    m_box(in_x[o], in_y[o], in_w[o], OBJ_COL[o]);
    mx[o] = in_x[o]; my[o] = in_y[o]; mw[o] = in_w[o];
  endtask

  task automatic m_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) exp_q.push_back({8'(x), 7'(y), BG});
    for (int o = 0; o < 3; o++) mw[o] = 0;
  endtask

  function automatic int seq_diff();
    int n = 0;
    int m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (got_q[i] !== exp_q[i]) n++;
    n += (got_q.size() > exp_q.size()) ? got_q.size() - m : exp_q.size() - m;
    return n;
  endfunction

  task automatic flush();
    got_q.delete(); exp_q.delete(); got_c.delete();
  endtask

  task automatic set_obj(input int o, input int x, input int y, input int w);
    in_x[o] = x; in_y[o] = y;
    case (o)
      0: begin bus.player_x = 8'(x); bus.player_y = 7'(y); in_w[0] = 3; end
      1: begin bus.bullet_x = 8'(x); bus.bullet_y = 7'(y); in_w[1] = 1; end
      default: begin bus.enemy_x = 8'(x); bus.enemy_y = 7'(y); bus.enemy_width = 3'(w); in_w[2] = w; end
    endcase
  endtask

  task automatic pulse(input bit p, input bit b, input bit e, input bit c);
    @(posedge clk); #1;
    bus.player_move = p; bus.bullet_move = b; bus.enemy_move = e; bus.clear = c;
    @(posedge clk); #1;
    t_pulse = cyc;
    bus.player_move = 1'b0; bus.bullet_move = 1'b0; bus.enemy_move = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < budget) begin @(negedge clk); n++; end
    ok = (bus.busy === 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.plot, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctrl: plot/busy=%b required 00", {bus.plot, bus.busy});
    end
    n_checks++;
    if ({bus.vga_x, bus.vga_y, bus.colour} !== 18'd0) begin
      n_fail++; $display("FAIL reset_pix: x=%0d y=%0d c=%b required 0 0 000", bus.vga_x, bus.vga_y, bus.colour);
    end
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({bus.plot, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset: plot/busy=%b required 00", {bus.plot, bus.busy});
    end
    flush();
  endtask

  task automatic test_first_draw();
    bit ok; int tp;
    set_obj(0, 80, 115, 3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tp = t_pulse;
    wait_idle(200, ok);
    m_obj(0);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL first_draw_timeout: busy still high, required low"); end
    n_checks++;
    if (got_q.size() !== 9) begin n_fail++; $display("FAIL first_draw_len: %0d plots, required 9", got_q.size()); end
    n_checks++;
    if (seq_diff() !== 0) begin n_fail++; $display("FAIL first_draw_seq: %0d pixel differences, required 0", seq_diff()); end
    n_checks++;
    if (((got_c.size() > 0) ? got_c[0] : -1) !== tp + 2) begin
      n_fail++; $display("FAIL first_plot_latency: cycle %0d, required %0d", (got_c.size() > 0) ? got_c[0] : -1, tp + 2);
    end
    flush();
  endtask

  task automatic test_move_erase();
    bit ok;
    set_obj(0, 79, 115, 3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle(200, ok);
    m_obj(0);
    n_checks++;
    if (got_q.size() !== 18) begin n_fail++; $display("FAIL move_erase_len: %0d plots, required 18", got_q.size()); end
    n_checks++;
    if (!ok || seq_diff() !== 0) begin n_fail++; $display("FAIL move_erase_seq: ok=%0d diffs=%0d, required 1 0", ok, seq_diff()); end
    flush();
  endtask

  task automatic test_back_to_back();
    bit ok;
    set_obj(0, $urandom_range(0, 157), $urandom_range(0, 117), 3);
    set_obj(1, $urandom_range(0, 159), $urandom_range(0, 119), 1);
    set_obj(2, $urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(1, 7));
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle(500, ok);
    m_obj(0); m_obj(1); m_obj(2);
    n_checks++;
    if (!ok || seq_diff() !== 0) begin
      n_fail++; $display("FAIL back_to_back_seq: ok=%0d diffs=%0d got=%0d exp=%0d", ok, seq_diff(), got_q.size(), exp_q.size());
    end
    flush();
  endtask

  task automatic test_clip();
    bit ok; int n_on = 0;
    set_obj(2, 158, 50, 3);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(200, ok);
    m_obj(2);
    foreach (got_q[i]) if (got_q[i][2:0] === 3'b100) n_on++;
    n_checks++;
    if (n_on !== 6) begin n_fail++; $display("FAIL clip_count: %0d enemy plots, required 6", n_on); end
    n_checks++;
    if (!ok || seq_diff() !== 0) begin n_fail++; $display("FAIL clip_seq: ok=%0d diffs=%0d, required 1 0", ok, seq_diff()); end
    flush();
    set_obj(2, 158, 50, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(200, ok);
    m_obj(2);
    n_checks++;
    if (!ok || got_q.size() !== 6 || seq_diff() !== 0) begin
      n_fail++; $display("FAIL dead_enemy_erase: plots=%0d diffs=%0d, required 6 0", got_q.size(), seq_diff());
    end
    flush();
  endtask

  task automatic test_random();
    bit ok; int o;
    for (int k = 0; k < 8; k++) begin
      o = $urandom_range(0, 2);
      set_obj(o, $urandom_range(0, 200), $urandom_range(0, 127), $urandom_range(0, 7));
      pulse(o == 0, o == 1, o == 2, 1'b0);
      wait_idle(300, ok);
      m_obj(o);
      n_checks++;
      if (!ok || seq_diff() !== 0) begin
        n_fail++; $display("FAIL random_move obj=%0d: ok=%0d diffs=%0d got=%0d exp=%0d", o, ok, seq_diff(), got_q.size(), exp_q.size());
      end
      flush();
    end
  endtask

  task automatic test_clear();
    bit ok; int n = 0;
    set_obj(0, 40, 40, 3);
    set_obj(1, 100, 10, 1);
    set_obj(2, 20, 30, 4);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    while (got_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(25000, ok);
    m_obj(2); m_clear(); m_obj(0); m_obj(1); m_obj(2);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL clear_timeout: busy still high, required low"); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL clear_len: %0d plots, required %0d", got_q.size(), exp_q.size()); end
    n_checks++;
    if (seq_diff() !== 0) begin n_fail++; $display("FAIL clear_seq: %0d pixel differences, required 0", seq_diff()); end
    flush();
  endtask

  task automatic test_reset_mid();
    bit ok; int n = 0;
    set_obj(0, 60, 60, 3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    while (got_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.plot, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid: plot/busy=%b required 00", {bus.plot, bus.busy});
    end
    for (int o = 0; o < 3; o++) begin mx[o] = 0; my[o] = 0; mw[o] = 0; end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    flush();
    set_obj(0, 70, 20, 3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle(200, ok);
    m_obj(0);
    n_checks++;
    if (!ok || got_q.size() !== 9 || seq_diff() !== 0) begin
      n_fail++; $display("FAIL after_reset_draw: plots=%0d diffs=%0d, required 9 0", got_q.size(), seq_diff());
    end
    flush();
  endtask

  initial begin
    reset = 1'b1;
    bus.clear = 1'b0; bus.player_move = 1'b0; bus.bullet_move = 1'b0; bus.enemy_move = 1'b0;
    bus.player_x = 8'd0; bus.player_y = 7'd0; bus.bullet_x = 8'd0; bus.bullet_y = 7'd0;
    bus.enemy_x = 8'd0; bus.enemy_y = 7'd0; bus.enemy_width = 3'd0;
    for (int o = 0; o < 3; o++) begin mx[o] = 0; my[o] = 0; mw[o] = 0; in_x[o] = 0; in_y[o] = 0; in_w[o] = 0; end
    in_w[0] = 3; in_w[1] = 1;
    test_reset();
    test_first_draw();
    test_move_erase();
    test_back_to_back();
    test_clip();
    test_random();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
